// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_t;

  localparam logic [3:0] REG_PC = 4'hF;

  // Memory-stage result wins over Writeback; R15 always comes from the PC path.
  function automatic fwd_sel_t fwd_select(
    input logic [3:0] ra,
    input logic [3:0] wa_m,
    input logic [3:0] wa_w,
    input logic       we_m,
    input logic       we_w
  );
    fwd_sel_t sel;
    sel = FWD_RF;
    if (ra != REG_PC) begin
      if (we_m && (wa_m == ra)) begin
        sel = FWD_M;
      end else if (we_w && (wa_w == ra)) begin
        sel = FWD_W;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/mc_stall_fsm.sv
// Holds the front of the pipeline while a multi-cycle op occupies Execute
// for MUL_CYCLES cycles.
module mc_stall_fsm
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic mul_start_e,
  output logic mcStall
);

  localparam int unsigned CNT_W = $clog2(MUL_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic MULTI = (MUL_CYCLES > 1);

  mc_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= MC_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Stall is Mealy in IDLE so the op is held from its very first cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mcStall   = 1'b0;
    if (!reset) begin
      case (state)
        MC_IDLE: begin
          if (mul_start_e && MULTI) begin
            mcStall   = 1'b1;
            cnt_nxt   = CNT_W'(1);
            state_nxt = MC_BUSY;
          end
        end
        MC_BUSY: begin
          if (cnt < LAST) begin
            mcStall = 1'b1;
            cnt_nxt = cnt + CNT_W'(1);
          end else begin
            cnt_nxt   = '0;
            state_nxt = MC_IDLE;
          end
        end
        default: begin
          cnt_nxt   = '0;
          state_nxt = MC_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: forwarding,
// load-use / PC-write / multi-cycle stalls, flushes and a stall counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 3,
  parameter int unsigned PERF_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        RA1D,
  input  logic [3:0]        RA2D,
  input  logic [3:0]        RA1E,
  input  logic [3:0]        RA2E,
  input  logic [3:0]        WA3E,
  input  logic [3:0]        WA3M,
  input  logic [3:0]        WA3W,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              PCSrcD,
  input  logic              PCSrcE,
  input  logic              PCSrcM,
  input  logic              PCSrcW,
  input  logic              BranchTakenE,
  input  logic              mul_start_e,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              mul_busy,
  output logic [PERF_W-1:0] stall_cnt
);

  logic mcStall;
  logic ldrStall;
  logic pcPend;

  mc_stall_fsm #(
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mc_fsm (
    .clk         (clk),
    .reset       (reset),
    .mul_start_e (mul_start_e),
    .mcStall     (mcStall)
  );

  always_comb begin
    ForwardAE = fwd_select(RA1E, WA3M, WA3W, RegWriteM, RegWriteW);
    ForwardBE = fwd_select(RA2E, WA3M, WA3W, RegWriteM, RegWriteW);
  end

  // A held Execute stage overrides any flush of Decode or Execute.
  always_comb begin
    ldrStall = MemtoRegE & RegWriteE & ((WA3E == RA1D) | (WA3E == RA2D));
    pcPend   = PCSrcD | PCSrcE | PCSrcM;
    StallF   = ldrStall | pcPend | mcStall;
    StallD   = ldrStall | mcStall;
    StallE   = mcStall;
    FlushD   = (pcPend | PCSrcW | BranchTakenE) & ~mcStall;
    FlushE   = (ldrStall | BranchTakenE) & ~mcStall;
    FlushM   = mcStall;
    mul_busy = mcStall;
  end

  // Saturating count of fetch-stall cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (StallF && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances (default, MUL_CYCLES=1,
// PERF_W=4) checked every cycle against an occupancy-based model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
  logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, mul_start_e;

  logic [1:0]  fa [3];
  logic [1:0]  fb [3];
  logic        stF [3];
  logic        stD [3];
  logic        stE [3];
  logic        flD [3];
  logic        flE [3];
  logic        flM [3];
  logic        busy [3];
  logic [31:0] cnt_a, cnt_b;
  logic [3:0]  cnt_c;

  int     checks = 0;
  int     errors = 0;
  int     age [3] = '{-1, -1, -1};
  longint mcnt [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  hazard_ctrl #(.MUL_CYCLES(3), .PERF_W(32)) dut_a (
    .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE),
    .PCSrcM(PCSrcM), .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .mul_start_e(mul_start_e),
    .ForwardAE(fa[0]), .ForwardBE(fb[0]), .StallF(stF[0]), .StallD(stD[0]), .StallE(stE[0]),
    .FlushD(flD[0]), .FlushE(flE[0]), .FlushM(flM[0]), .mul_busy(busy[0]), .stall_cnt(cnt_a));

  hazard_ctrl #(.MUL_CYCLES(1), .PERF_W(32)) dut_b (
    .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE),
    .PCSrcM(PCSrcM), .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .mul_start_e(mul_start_e),
    .ForwardAE(fa[1]), .ForwardBE(fb[1]), .StallF(stF[1]), .StallD(stD[1]), .StallE(stE[1]),
    .FlushD(flD[1]), .FlushE(flE[1]), .FlushM(flM[1]), .mul_busy(busy[1]), .stall_cnt(cnt_b));

  hazard_ctrl #(.MUL_CYCLES(3), .PERF_W(4)) dut_c (
    .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE),
    .PCSrcM(PCSrcM), .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .mul_start_e(mul_start_e),
    .ForwardAE(fa[2]), .ForwardBE(fb[2]), .StallF(stF[2]), .StallD(stD[2]), .StallE(stE[2]),
    .FlushD(flD[2]), .FlushE(flE[2]), .FlushM(flM[2]), .mul_busy(busy[2]), .stall_cnt(cnt_c));

  // ---------------- model ----------------
  function automatic int mcv(input int i);
    return (i == 1) ? 1 : 3;
  endfunction

  function automatic longint sat(input int i);
    return (i == 2) ? 64'd15 : 64'hFFFF_FFFF;
  endfunction

  // Cycles the current multi-cycle op has spent in Execute (-1: none).
  function automatic int eff_age(input int i);
    int a;
    a = age[i];
    if (a < 0 && mul_start_e) a = 0;
    return a;
  endfunction

  function automatic bit m_mc(input int i);
    int a;
    a = eff_age(i);
    return !reset && (a >= 0) && (a < mcv(i) - 1);
  endfunction

  function automatic int m_fwd(input logic [3:0] ra);
    if (ra == 4'd15) return 0;
    if (RegWriteM && WA3M == ra) return 2;
    if (RegWriteW && WA3W == ra) return 1;
    return 0;
  endfunction

  function automatic bit m_ldr();
    return MemtoRegE && RegWriteE && (WA3E == RA1D || WA3E == RA2D);
  endfunction

  function automatic bit m_pc();
    return PCSrcD || PCSrcE || PCSrcM;
  endfunction

  function automatic bit m_stallf(input int i);
    return m_ldr() || m_pc() || m_mc(i);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        age[i]  <= -1;
        mcnt[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        age[i]  <= m_mc(i) ? eff_age(i) + 1 : -1;
        mcnt[i] <= (m_stallf(i) && mcnt[i] < sat(i)) ? mcnt[i] + 1 : mcnt[i];
      end
    end
  end

  // ---------------- checking ----------------
  task automatic cmp(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint act_cnt(input int i);
    case (i)
      0: return longint'(cnt_a);
      1: return longint'(cnt_b);
      default: return longint'(cnt_c);
    endcase
  endfunction

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      bit mc;
      bit ldr;
      bit pc;
      mc  = m_mc(i);
      ldr = m_ldr();
      pc  = m_pc();
      cmp($sformatf("ForwardAE[%0d]", i), longint'(fa[i]), longint'(m_fwd(RA1E)));
      cmp($sformatf("ForwardBE[%0d]", i), longint'(fb[i]), longint'(m_fwd(RA2E)));
      cmp($sformatf("StallF[%0d]", i), longint'(stF[i]), longint'(ldr | pc | mc));
      cmp($sformatf("StallD[%0d]", i), longint'(stD[i]), longint'(ldr | mc));
      cmp($sformatf("StallE[%0d]", i), longint'(stE[i]), longint'(mc));
      cmp($sformatf("FlushD[%0d]", i), longint'(flD[i]),
          longint'((pc | PCSrcW | BranchTakenE) & ~mc));
      cmp($sformatf("FlushE[%0d]", i), longint'(flE[i]), longint'((ldr | BranchTakenE) & ~mc));
      cmp($sformatf("FlushM[%0d]", i), longint'(flM[i]), longint'(mc));
      cmp($sformatf("mul_busy[%0d]", i), longint'(busy[i]), longint'(mc));
      cmp($sformatf("stall_cnt[%0d]", i), act_cnt(i), mcnt[i]);
    end
  endtask

  always @(negedge clk) check_all();

  // ---------------- stimulus ----------------
  task automatic clr();
    {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE} = '0;
    {PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, mul_start_e} = '0;
    RA1D = 4'd1; RA2D = 4'd2; RA1E = 4'd1; RA2E = 4'd2;
    WA3E = 4'd9; WA3M = 4'd10; WA3W = 4'd11;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic look();
    @(negedge clk); #1;
  endtask

  initial begin
    clr();
    look();
    cmp("lit_reset_cnt", longint'(cnt_a), 0);
    cmp("lit_reset_stallE", longint'(stE[0]), 0);
    tick(); reset = 1'b0;

    // forwarding priority
    RegWriteM = 1; WA3M = 4'd3; RegWriteW = 1; WA3W = 4'd3; RA1E = 4'd3; RA2E = 4'd3;
    look(); cmp("lit_fwdA_M", longint'(fa[0]), 2); cmp("lit_fwdB_M", longint'(fb[0]), 2);
    tick(); RegWriteM = 0;
    look(); cmp("lit_fwdA_W", longint'(fa[0]), 1);
    tick(); RA1E = 4'd15;
    look(); cmp("lit_fwdA_pc", longint'(fa[0]), 0); cmp("lit_fwdB_W", longint'(fb[0]), 1);
    tick(); clr();

    // load-use
    MemtoRegE = 1; RegWriteE = 1; WA3E = 4'd5; RA2D = 4'd5;
    look(); cmp("lit_ldr_stallF", longint'(stF[0]), 1); cmp("lit_ldr_flushE", longint'(flE[0]), 1);
    tick(); clr();
    look(); cmp("lit_ldr_cnt", longint'(cnt_a), 1);

    // branch then PC-write sequence
    tick(); BranchTakenE = 1;
    look(); cmp("lit_br_flushD", longint'(flD[0]), 1); cmp("lit_br_stallF", longint'(stF[0]), 0);
    tick(); BranchTakenE = 0; PCSrcD = 1;
    look(); cmp("lit_pcd_stallF", longint'(stF[0]), 1);
    tick(); PCSrcD = 0; PCSrcE = 1;
    tick(); PCSrcE = 0; PCSrcM = 1;
    tick(); PCSrcM = 0; PCSrcW = 1;
    look(); cmp("lit_pcw_flushD", longint'(flD[0]), 1); cmp("lit_pcw_stallF", longint'(stF[0]), 0);
    tick(); clr();
    look(); cmp("lit_pc_cnt", longint'(cnt_a), 4);

    // multi-cycle op held for its 3-cycle occupancy
    tick(); mul_start_e = 1;
    look(); cmp("lit_mc0_stallE", longint'(stE[0]), 1); cmp("lit_mc0_m1", longint'(stE[1]), 0);
    tick();
    look(); cmp("lit_mc1_flushM", longint'(flM[0]), 1);
    tick();
    look(); cmp("lit_mc2_stallE", longint'(stE[0]), 0);
    tick(); mul_start_e = 0;
    look(); cmp("lit_mc_cnt", longint'(cnt_a), 6);

    // back-to-back ops plus an overlapping branch
    tick(); mul_start_e = 1; BranchTakenE = 1;
    for (int k = 0; k < 6; k++) tick();
    clr();

    // reset in the middle of an op
    tick(); mul_start_e = 1;
    tick();
    look(); cmp("lit_busy_before_rst", longint'(stE[0]), 1);
    reset = 1'b1; #1;
    cmp("lit_rst_stallE", longint'(stE[0]), 0);
    check_all();
    mul_start_e = 0;
    tick(); tick(); reset = 1'b0;
    look(); cmp("lit_post_rst_cnt", longint'(cnt_a), 0);
    tick(); mul_start_e = 1;
    look(); cmp("lit_post_rst_idle", longint'(stE[0]), 1);
    tick(); tick(); tick(); clr();

    // saturation of the 4-bit counter
    PCSrcD = 1;
    for (int k = 0; k < 20; k++) tick();
    clr();
    look(); cmp("lit_sat_c", longint'(cnt_c), 15); cmp("lit_sat_a", longint'(cnt_a), 22);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
